// File: rtl/byte_queue.sv
// Byte FIFO behind the serial deserializer: one push per data_ready level, acked by a one-cycle pulse.
// Build option BYTE_QUEUE_DROP_EN: ack and discard bytes arriving while full, setting a sticky overflow flag.
module byte_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk_100KHz,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     data_ready_in,
  output logic                     ack_out,
  input  logic                     dequeue_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     valid_out,
  output logic [$clog2(DEPTH):0]   len_out,
  output logic                     full_out,
  output logic                     empty_out,
  output logic                     overflow_out,
  output logic [1:0]               state_dbg_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACK      = 2'd1,
    S_WAIT_LOW = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    len_q, len_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic full, empty, accept, push, pop;

  assign full  = (len_q == LW'(DEPTH));
  assign empty = (len_q == '0);

  // full is judged on the registered count, so a pop never frees room for a push in the same cycle
`ifdef BYTE_QUEUE_DROP_EN
  assign accept = (state_q == S_IDLE) && data_ready_in;
`else
  assign accept = (state_q == S_IDLE) && data_ready_in && !full;
`endif
  assign push = accept && !full;
  assign pop  = dequeue_in && !empty;

  // Input FSM: state register
  always_ff @(posedge clk_100KHz or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Input FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (accept) state_d = S_ACK;
      S_ACK:      state_d = data_ready_in ? S_WAIT_LOW : S_IDLE;
      S_WAIT_LOW: if (!data_ready_in) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Input FSM: outputs
  always_comb begin
    ack_out       = 1'b0;
    state_dbg_out = state_q;
    if (state_q == S_ACK) ack_out = 1'b1;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    len_d    = len_q;
    dout_d   = dout_q;
    valid_d  = pop;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      dout_d   = mem_q[rd_ptr_q];
    end
    if (push && !pop)      len_d = len_q + LW'(1);
    else if (pop && !push) len_d = len_q - LW'(1);
  end

  always_ff @(posedge clk_100KHz or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      len_q    <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      len_q    <= len_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
    end
  end

  // Storage needs no reset; only the pointers define what is valid
  always_ff @(posedge clk_100KHz) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

`ifdef BYTE_QUEUE_DROP_EN
  logic ovf_q, ovf_d;
  assign ovf_d = ovf_q | (accept && full);
  always_ff @(posedge clk_100KHz or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end
  assign overflow_out = ovf_q;
`else
  assign overflow_out = 1'b0;
`endif

  assign data_out  = dout_q;
  assign valid_out = valid_q;
  assign len_out   = len_q;
  assign full_out  = full;
  assign empty_out = empty;

endmodule

// File: tb/tb_byte_queue.sv
// Bench for byte_queue: vector table, directed corner sequences and random traffic against a queue-based model.
module tb_byte_queue;

`ifdef BYTE_QUEUE_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic       clk_100KHz = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_ready_in;
  logic       ack_out;
  logic       dequeue_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic [3:0] len_out;
  logic       full_out;
  logic       empty_out;
  logic       overflow_out;
  logic [1:0] state_dbg_out;

  byte_queue #(.DEPTH(8), .WIDTH(8)) dut (
    .clk_100KHz    (clk_100KHz),
    .reset         (reset),
    .data_in       (data_in),
    .data_ready_in (data_ready_in),
    .ack_out       (ack_out),
    .dequeue_in    (dequeue_in),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .len_out       (len_out),
    .full_out      (full_out),
    .empty_out     (empty_out),
    .overflow_out  (overflow_out),
    .state_dbg_out (state_dbg_out)
  );

  // clock / reset
  always #5 clk_100KHz = ~clk_100KHz;

  int checks = 0;
  int errors = 0;

  // reference model: plain byte queue plus "level already consumed" bookkeeping
  logic [7:0] exp_q[$];
  bit         m_ack, m_valid, m_ovf, m_armed;
  logic [7:0] m_dout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ack = 0; m_valid = 0; m_ovf = 0; m_armed = 1; m_dout = 8'h00;
  endtask

  // A byte is taken once per data_ready level, never in the cycle its ack is showing,
  // and only when there is room (or always, when drops are enabled).
  task automatic model_step(input bit rdy, input logic [7:0] d, input bit deq);
    int  len;
    bit  full, accept, pop;
    len    = exp_q.size();
    full   = (len == 8);
    accept = rdy && !m_ack && m_armed && (!full || DROP);
    pop    = deq && (len > 0);
    m_valid = pop;
    if (pop) m_dout = exp_q.pop_front();
    if (accept && !full) exp_q.push_back(d);
    if (accept && full) m_ovf = 1;
    if (accept) m_armed = 0;
    else if (!rdy) m_armed = 1;
    m_ack = accept;
  endtask

  task automatic compare_all();
    chk("ack", ack_out, m_ack);
    chk("valid", valid_out, m_valid);
    chk("data", data_out, m_dout);
    chk("len", len_out, exp_q.size());
    chk("full", full_out, exp_q.size() == 8);
    chk("empty", empty_out, exp_q.size() == 0);
    chk("overflow", overflow_out, m_ovf);
  endtask

  // driver: inputs applied at negedge, outputs checked at the following negedge
  task automatic tick(input bit rdy, input logic [7:0] d, input bit deq);
    data_ready_in = rdy;
    data_in       = d;
    dequeue_in    = deq;
    @(posedge clk_100KHz);
    model_step(rdy, d, deq);
    @(negedge clk_100KHz);
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ack"}, ack_out, 0);
    chk({tag, "_valid"}, valid_out, 0);
    chk({tag, "_data"}, data_out, 0);
    chk({tag, "_len"}, len_out, 0);
    chk({tag, "_empty"}, empty_out, 1);
    chk({tag, "_full"}, full_out, 0);
    chk({tag, "_ovf"}, overflow_out, 0);
  endtask

  task automatic do_reset();
    data_ready_in = 0; data_in = 0; dequeue_in = 0;
    reset = 1;
    #1;
    check_reset_values("reset");
    model_reset();
    @(negedge clk_100KHz);
    reset = 0;
  endtask

  task automatic push_byte(input logic [7:0] d);
    tick(1, d, 0);
    tick(0, 8'h00, 0);
  endtask

  typedef struct {
    bit         rdy;
    logic [7:0] d;
    bit         deq;
    bit         e_ack;
    bit         e_valid;
    logic [7:0] e_dout;
    int         e_len;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int k;
    vecs[0] = '{1, 8'hAD, 0, 1, 0, 8'h00, 1};  // push 0xAD
    vecs[1] = '{0, 8'h00, 0, 0, 0, 8'h00, 1};
    vecs[2] = '{0, 8'h00, 1, 0, 1, 8'hAD, 0};  // pop 0xAD
    vecs[3] = '{0, 8'h00, 1, 0, 0, 8'hAD, 0};  // pop while empty
    vecs[4] = '{1, 8'h3C, 0, 1, 0, 8'hAD, 1};  // 0x3C held 5 cycles
    vecs[5] = '{1, 8'h3C, 0, 0, 0, 8'hAD, 1};
    vecs[6] = '{1, 8'h3C, 0, 0, 0, 8'hAD, 1};
    vecs[7] = '{1, 8'h3C, 0, 0, 0, 8'hAD, 1};
    vecs[8] = '{1, 8'h3C, 0, 0, 0, 8'hAD, 1};
    vecs[9] = '{0, 8'h00, 0, 0, 0, 8'hAD, 1};

    reset = 1; data_ready_in = 0; data_in = 0; dequeue_in = 0;
    @(negedge clk_100KHz);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      tick(vecs[i].rdy, vecs[i].d, vecs[i].deq);
      chk($sformatf("vec%0d_ack", i), ack_out, vecs[i].e_ack);
      chk($sformatf("vec%0d_valid", i), valid_out, vecs[i].e_valid);
      chk($sformatf("vec%0d_data", i), data_out, vecs[i].e_dout);
      chk($sformatf("vec%0d_len", i), len_out, vecs[i].e_len);
    end

    // fill to full, then the over-full byte
    do_reset();
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    chk("fill_len", len_out, 8);
    chk("fill_full", full_out, 1);
`ifdef BYTE_QUEUE_DROP_EN
    tick(1, 8'hEE, 0);
    chk("drop_ack", ack_out, 1);
    chk("drop_ovf", overflow_out, 1);
    chk("drop_len", len_out, 8);
    tick(0, 8'h00, 0);
    tick(0, 8'h00, 0);
    chk("drop_ovf_sticky", overflow_out, 1);
    for (int i = 1; i <= 8; i++) begin
      tick(0, 8'h00, 1);
      chk("drop_pop", data_out, i);
    end
`else
    for (int i = 0; i < 4; i++) begin
      tick(1, 8'h09, 0);
      chk("bp_no_ack", ack_out, 0);
    end
    tick(1, 8'h09, 1);
    chk("bp_pop_data", data_out, 8'h01);
    chk("bp_pop_valid", valid_out, 1);
    chk("bp_pop_ack", ack_out, 0);
    chk("bp_pop_len", len_out, 7);
    tick(1, 8'h09, 0);
    chk("bp_late_ack", ack_out, 1);
    chk("bp_late_len", len_out, 8);
    tick(0, 8'h00, 0);
    for (int i = 2; i <= 9; i++) begin
      tick(0, 8'h00, 1);
      chk("bp_drain", data_out, i);
    end
`endif

    // interleaved traffic across the pointer wrap
    do_reset();
    k = 0;
    for (int i = 0; i < 10; i++) begin
      for (int p = 0; p < 2; p++) begin
        tick(p == 0, 8'h10 + 8'(i), i >= 3);
        chk("wrap_len_max", len_out <= 8, 1);
        if (valid_out) begin
          chk("wrap_order", data_out, 8'h10 + 8'(k));
          k++;
        end
      end
    end
    for (int i = 0; i < 12; i++) begin
      tick(0, 8'h00, 1);
      if (valid_out) begin
        chk("wrap_order", data_out, 8'h10 + 8'(k));
        k++;
      end
    end
    chk("wrap_pop_count", k, 10);

    // simultaneous push and pop at occupancy 3
    do_reset();
    for (int i = 0; i < 3; i++) push_byte(8'h60 + 8'(i));
    tick(1, 8'h77, 1);
    chk("pp_len", len_out, 3);
    chk("pp_valid", valid_out, 1);
    chk("pp_ack", ack_out, 1);
    chk("pp_data", data_out, 8'h60);

    // asynchronous reset while an ack is showing and five bytes are queued
    do_reset();
    for (int i = 0; i < 4; i++) push_byte(8'hC0 + 8'(i));
    tick(1, 8'hA5, 0);
    chk("mid_len", len_out, 5);
    chk("mid_ack", ack_out, 1);
    #2;
    reset = 1;
    #1;
    check_reset_values("mid_reset");
    model_reset();
    data_ready_in = 0;
    @(negedge clk_100KHz);
    reset = 0;
    push_byte(8'h55);
    tick(0, 8'h00, 1);
    chk("post_reset_pop", data_out, 8'h55);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      tick($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 35);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
